ip_frame_sender: RTL and testbench
==================================

# ip_frame_sender

Load-balancer-side transmitter that builds the Ethernet/IPv4 frames the accelerator's receive path consumes. It latches a destination, a source identity and a USER_DATA_BYTES-wide payload on a start handshake. It computes the IPv4 header checksum, then streams the frame byte-wise on an AXI-Stream master into the TX FIFO/MAC. It also serves as the bench/host-side driver for the accelerator's RX path.

## Interface
- USER_DATA_BYTES, 785, payload bytes per frame; legal range 1..1480.
- IP_PROTOCOL, 8'hFD, IPv4 protocol field.
- IP_TTL, 8'h40, IPv4 TTL field.

- ACLK  in  1  clock; all logic on rising edge.
- ARESET  in  1  synchronous, active-high reset.
- SRC_IP_ADDRESS  in  32  sender IP.
- SRC_MAC_ADDRESS  in  48  sender MAC.
- DEST_IP_ADDRESS  in  32  accelerator IP.
- DEST_MAC_ADDRESS  in  48  accelerator MAC.
- PAYLOAD  in  USER_DATA_BYTES*8  frame data; byte 0 is PAYLOAD[USER_DATA_BYTES*8-1 -: 8].
- START  in  1  request a frame; accepted only when READY=1.
- READY  out  1  idle and able to accept START.
- TX_AXIS_TDATA  out  8  frame byte.
- TX_AXIS_TVALID  out  1  byte valid.
- TX_AXIS_TLAST  out  1  final byte of frame.
- TX_AXIS_TREADY  in  1  sink ready.
- FRAMES_SENT  out  16  count of completed frames; wraps.

## Operation
- States: IDLE, CSUM, SEND.
- IDLE: READY=1. When START=1 at an edge:
  - latch all address inputs and PAYLOAD;
  - latch ID = FRAMES_SENT;
  - go to CSUM.
- CSUM: one cycle.
  - Registered IPv4 checksum = ~(one's-complement sum of the ten header 16-bit words, with the checksum word taken as 0).
  - Carries are folded twice; the result is 16 bits.
  - Then go to SEND with byte index 0.
- SEND frame layout, 34+USER_DATA_BYTES bytes, MSB-first within each field:
  - bytes 0-5 DEST_MAC; 6-11 SRC_MAC; 12-13 0x08 0x00;
  - 14 0x45; 15 0x00; 16-17 total length = 20+USER_DATA_BYTES;
  - 18-19 ID; 20-21 0x40 0x00 (DF); 22 IP_TTL; 23 IP_PROTOCOL; 24-25 checksum;
  - 26-29 SRC_IP; 30-33 DEST_IP;
  - 34.. payload byte 0 upward.
- The byte index advances only on TVALID&TREADY. The index counter is $clog2(34+USER_DATA_BYTES) bits wide.
- TLAST=1 only while the index equals 33+USER_DATA_BYTES.
- On the last-byte handshake:
  - FRAMES_SENT increments, 0xFFFF wraps to 0x0000;
  - the block returns to IDLE.
- Inputs changing after acceptance have no effect on the frame in flight.
- START while READY=0 is ignored and not queued.

## Timing
- Reset values: READY=1, TX_AXIS_TVALID=0, TX_AXIS_TLAST=0, TX_AXIS_TDATA=0x00, FRAMES_SENT=0, state IDLE.
- READY drops in the cycle after the accepting edge.
- TVALID first rises 2 cycles after the accepting edge (1 cycle in CSUM).
- TVALID stays high continuously through the frame, with no bubbles.
- While TVALID=1 and TREADY=0, TDATA and TLAST hold stable.
- READY returns in the cycle after the last-byte handshake. TVALID and TLAST are 0 in that same cycle.
- Back-to-back: a START sampled in that cycle is accepted. Minimum inter-frame gap is 2 idle TVALID cycles.
- With TREADY held at 1, a frame occupies TVALID for exactly 34+USER_DATA_BYTES cycles.
- ARESET mid-frame:
  - outputs reach reset values at the next edge;
  - no TLAST is emitted;
  - FRAMES_SENT returns to 0;
  - the partial frame is abandoned.
- ARESET together with START: reset wins and START is dropped.

## Test plan
- Reset: assert ARESET 3 cycles -> READY=1, TVALID=0, TLAST=0, TDATA=0x00, FRAMES_SENT=0.
- Nominal frame, setup: USER_DATA_BYTES=785, SRC 10.0.0.2, DEST 10.0.0.1, incrementing payload, TREADY=1.
  - Frame length: exactly 819 bytes; TLAST only on byte 818.
  - Header bytes: 16-17 = 03 25, 18-19 = 00 00, 24-25 = 22 DA.
  - Byte 34 = PAYLOAD top byte.
  - Completion: FRAMES_SENT=1.
- Backpressure: repeat with TREADY random 50% -> byte sequence identical to the nominal frame; TDATA/TLAST stable on every stalled cycle; no TVALID gaps.
- Back-to-back: assert START again in the first cycle READY=1 -> second frame has ID bytes 00 01 and checksum 22 D9; the gap between frames is 2 cycles.
- Carry fold: SRC_IP 255.255.255.255, ID 0 -> checksum bytes 2C DC.
- Abort: ARESET pulse at byte index 100 -> TVALID=0 next cycle, no TLAST, READY=1, FRAMES_SENT=0; the next frame is complete and correct with ID 00 00.

Source files
------------

// File: rtl/ip_frame_sender.sv
// Builds one Ethernet/IPv4 frame per accepted START and streams it byte-wise on AXI-Stream.
// The whole frame is held in a shift register; TDATA is always its top byte.
//
// state | meaning
// IDLE  | READY high, waiting for START
// CSUM  | one cycle: IPv4 header checksum folded into the frame image
// SEND  | frame bytes streamed, index advances on TVALID & TREADY
module ip_frame_sender #(
  parameter int          USER_DATA_BYTES = 785,
  parameter logic [7:0]  IP_PROTOCOL     = 8'hFD,
  parameter logic [7:0]  IP_TTL          = 8'h40
) (
  input  logic                         ACLK,
  input  logic                         ARESET,
  input  logic [31:0]                  SRC_IP_ADDRESS,
  input  logic [47:0]                  SRC_MAC_ADDRESS,
  input  logic [31:0]                  DEST_IP_ADDRESS,
  input  logic [47:0]                  DEST_MAC_ADDRESS,
  input  logic [USER_DATA_BYTES*8-1:0] PAYLOAD,
  input  logic                         START,
  output logic                         READY,
  output logic [7:0]                   TX_AXIS_TDATA,
  output logic                         TX_AXIS_TVALID,
  output logic                         TX_AXIS_TLAST,
  input  logic                         TX_AXIS_TREADY,
  output logic [15:0]                  FRAMES_SENT
);

  localparam int FRAME_BYTES = 34 + USER_DATA_BYTES;
  localparam int FRAME_BITS  = FRAME_BYTES * 8;
  localparam int IDX_W       = $clog2(FRAME_BYTES);
  localparam int IP_HDR_MSB  = FRAME_BITS - 1 - 14 * 8;
  localparam int CSUM_MSB    = FRAME_BITS - 1 - 24 * 8;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(FRAME_BYTES - 1);
  localparam logic [15:0]      TOTAL_LEN = 16'(20 + USER_DATA_BYTES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CSUM = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic [15:0]           frames_sent_q, frames_sent_d;

  logic [159:0] ip_hdr;
  logic [19:0]  sum;
  logic [16:0]  fold1;
  logic [15:0]  fold2;
  logic [15:0]  csum;

  // The checksum field is loaded as zero, so summing all ten words is correct.
  always_comb begin
    ip_hdr = frame_q[IP_HDR_MSB -: 160];
    sum    = '0;
    for (int k = 0; k < 10; k++) begin
      sum = sum + {4'd0, ip_hdr[159-16*k -: 16]};
    end
    fold1 = {1'b0, sum[15:0]} + {13'd0, sum[19:16]};
    fold2 = fold1[15:0] + {15'd0, fold1[16]};
    csum  = ~fold2;
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    frame_d       = frame_q;
    frames_sent_d = frames_sent_q;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          frame_d = {DEST_MAC_ADDRESS, SRC_MAC_ADDRESS, 16'h0800,
                     8'h45, 8'h00, TOTAL_LEN, frames_sent_q, 16'h4000,
                     IP_TTL, IP_PROTOCOL, 16'h0000,
                     SRC_IP_ADDRESS, DEST_IP_ADDRESS, PAYLOAD};
          state_d = S_CSUM;
        end
      end
      S_CSUM: begin
        frame_d[CSUM_MSB -: 16] = csum;
        idx_d   = '0;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (TX_AXIS_TREADY) begin
          frame_d = {frame_q[FRAME_BITS-9:0], 8'h00};
          if (idx_q == LAST_IDX) begin
            idx_d         = '0;
            frames_sent_d = frames_sent_q + 16'd1;
            state_d       = S_IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      frame_q       <= '0;
      frames_sent_q <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      frame_q       <= frame_d;
      frames_sent_q <= frames_sent_d;
    end
  end

  assign READY          = (state_q == S_IDLE);
  assign TX_AXIS_TVALID = (state_q == S_SEND);
  assign TX_AXIS_TLAST  = (state_q == S_SEND) && (idx_q == LAST_IDX);
  assign TX_AXIS_TDATA  = frame_q[FRAME_BITS-1 -: 8];
  assign FRAMES_SENT    = frames_sent_q;

endmodule

// File: tb/tb_ip_frame_sender.sv
// Self-checking bench for ip_frame_sender: frames are compared against a byte-array model
// built from the field layout, with randomized backpressure and field values.
module tb_ip_frame_sender;
  localparam int N  = 785;
  localparam int FB = 34 + N;

  localparam logic [47:0] MAC_DST = 48'h02_AA_BB_CC_DD_01;
  localparam logic [47:0] MAC_SRC = 48'h02_11_22_33_44_02;
  localparam logic [31:0] IP_DST  = 32'h0A00_0001;
  localparam logic [31:0] IP_SRC  = 32'h0A00_0002;

  logic           ACLK = 1'b0;
  logic           ARESET;
  logic [31:0]    SRC_IP_ADDRESS;
  logic [47:0]    SRC_MAC_ADDRESS;
  logic [31:0]    DEST_IP_ADDRESS;
  logic [47:0]    DEST_MAC_ADDRESS;
  logic [N*8-1:0] PAYLOAD;
  logic           START;
  logic           READY;
  logic [7:0]     TX_AXIS_TDATA;
  logic           TX_AXIS_TVALID;
  logic           TX_AXIS_TLAST;
  logic           TX_AXIS_TREADY;
  logic [15:0]    FRAMES_SENT;

  ip_frame_sender #(.USER_DATA_BYTES(N)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .SRC_IP_ADDRESS(SRC_IP_ADDRESS), .SRC_MAC_ADDRESS(SRC_MAC_ADDRESS),
    .DEST_IP_ADDRESS(DEST_IP_ADDRESS), .DEST_MAC_ADDRESS(DEST_MAC_ADDRESS),
    .PAYLOAD(PAYLOAD), .START(START), .READY(READY),
    .TX_AXIS_TDATA(TX_AXIS_TDATA), .TX_AXIS_TVALID(TX_AXIS_TVALID),
    .TX_AXIS_TLAST(TX_AXIS_TLAST), .TX_AXIS_TREADY(TX_AXIS_TREADY),
    .FRAMES_SENT(FRAMES_SENT)
  );

  always #5 ACLK = ~ACLK;

  int checks = 0;
  int errors = 0;
  int exp_count = 0;
  int first_bad;

  logic [7:0]     exp_bytes [FB];
  logic [7:0]     cap_bytes [$];
  logic [N*8-1:0] nom_payload;
  int  cap_last_pos, cap_nlast, cap_stall_err, cap_gaps, cap_pre_idle;
  bit  cap_timeout;

  task automatic build_expected(input logic [47:0] dmac, input logic [47:0] smac,
                                input logic [31:0] sip, input logic [31:0] dip,
                                input logic [15:0] id, input logic [N*8-1:0] pl);
    int s;
    for (int i = 0; i < 6; i++) begin
      exp_bytes[i]     = dmac[47-8*i -: 8];
      exp_bytes[6 + i] = smac[47-8*i -: 8];
    end
    exp_bytes[12] = 8'h08; exp_bytes[13] = 8'h00;
    exp_bytes[14] = 8'h45; exp_bytes[15] = 8'h00;
    exp_bytes[16] = 8'((20 + N) / 256); exp_bytes[17] = 8'((20 + N) % 256);
    exp_bytes[18] = id[15:8]; exp_bytes[19] = id[7:0];
    exp_bytes[20] = 8'h40; exp_bytes[21] = 8'h00;
    exp_bytes[22] = 8'h40; exp_bytes[23] = 8'hFD;
    exp_bytes[24] = 8'h00; exp_bytes[25] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      exp_bytes[26 + i] = sip[31-8*i -: 8];
      exp_bytes[30 + i] = dip[31-8*i -: 8];
    end
    for (int i = 0; i < N; i++) exp_bytes[34 + i] = pl[N*8-1-8*i -: 8];
    s = 0;
    for (int w = 0; w < 10; w++) s += exp_bytes[14 + 2*w] * 256 + exp_bytes[15 + 2*w];
    while (s > 65535) s = (s % 65536) + (s / 65536);
    s = 65535 - s;
    exp_bytes[24] = 8'(s / 256);
    exp_bytes[25] = 8'(s % 256);
  endtask

  function automatic int frame_mismatches();
    int n;
    n = 0;
    first_bad = -1;
    for (int i = 0; i < FB; i++) begin
      if (i >= cap_bytes.size() || cap_bytes[i] !== exp_bytes[i]) begin
        n++;
        if (first_bad < 0) first_bad = i;
      end
    end
    return n;
  endfunction

  function automatic logic [7:0] cap_at(input int i);
    if (i < cap_bytes.size()) return cap_bytes[i];
    return 8'hxx;
  endfunction

  function automatic logic [N*8-1:0] rand_payload();
    logic [N*8-1:0] p;
    for (int i = 0; i < N; i++) p[N*8-1-8*i -: 8] = 8'($urandom);
    return p;
  endfunction

  task automatic drive_fields(input logic [47:0] dmac, input logic [47:0] smac,
                              input logic [31:0] sip, input logic [31:0] dip,
                              input logic [N*8-1:0] pl);
    DEST_MAC_ADDRESS = dmac; SRC_MAC_ADDRESS = smac;
    SRC_IP_ADDRESS = sip; DEST_IP_ADDRESS = dip; PAYLOAD = pl;
  endtask

  // Called just after a negedge; leaves the caller at the negedge following acceptance.
  task automatic start_frame(input logic [47:0] dmac, input logic [47:0] smac,
                             input logic [31:0] sip, input logic [31:0] dip,
                             input logic [N*8-1:0] pl);
    drive_fields(dmac, smac, sip, dip, pl);
    START = 1'b1;
    @(negedge ACLK);
    START = 1'b0;
  endtask

  // Collects handshaken bytes; returns before the edge that takes the TLAST byte.
  task automatic capture(input int ready_pct, input int abort_at);
    bit started, have_prev, rdy;
    logic [7:0] prev_d;
    logic prev_l;
    cap_bytes.delete();
    cap_last_pos = -1; cap_nlast = 0; cap_stall_err = 0;
    cap_gaps = 0; cap_pre_idle = 0; cap_timeout = 1;
    started = 0; have_prev = 0; prev_d = '0; prev_l = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc > 0) @(negedge ACLK);
      if (have_prev && (TX_AXIS_TVALID !== 1'b1 || TX_AXIS_TDATA !== prev_d ||
                        TX_AXIS_TLAST !== prev_l)) cap_stall_err++;
      have_prev = 0;
      if (TX_AXIS_TVALID === 1'b1) started = 1;
      else if (started) cap_gaps++;
      else cap_pre_idle++;
      if (abort_at >= 0 && started && cap_bytes.size() == abort_at) begin
        ARESET = 1'b1;
        TX_AXIS_TREADY = 1'b1;
        cap_timeout = 0;
        break;
      end
      rdy = ($urandom_range(99) < ready_pct);
      TX_AXIS_TREADY = rdy;
      if (TX_AXIS_TVALID === 1'b1) begin
        if (rdy) begin
          cap_bytes.push_back(TX_AXIS_TDATA);
          if (TX_AXIS_TLAST === 1'b1) begin
            cap_nlast++;
            cap_last_pos = cap_bytes.size() - 1;
            cap_timeout = 0;
            break;
          end
        end else begin
          have_prev = 1; prev_d = TX_AXIS_TDATA; prev_l = TX_AXIS_TLAST;
        end
      end
    end
  endtask

  task automatic do_reset();
    @(negedge ACLK);
    ARESET = 1'b1; START = 1'b0;
    repeat (3) @(negedge ACLK);
    ARESET = 1'b0;
    exp_count = 0;
  endtask

  task automatic test_reset();
    @(negedge ACLK);
    ARESET = 1'b1; START = 1'b0; TX_AXIS_TREADY = 1'b0;
    repeat (3) @(negedge ACLK);
    checks++; if (READY !== 1'b1) begin errors++; $display("FAIL reset_ready got %b expected 1", READY); end
    checks++; if (TX_AXIS_TVALID !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b expected 0", TX_AXIS_TVALID); end
    checks++; if (TX_AXIS_TLAST !== 1'b0) begin errors++; $display("FAIL reset_tlast got %b expected 0", TX_AXIS_TLAST); end
    checks++; if (TX_AXIS_TDATA !== 8'h00) begin errors++; $display("FAIL reset_tdata got %h expected 00", TX_AXIS_TDATA); end
    checks++; if (FRAMES_SENT !== 16'h0000) begin errors++; $display("FAIL reset_frames got %h expected 0000", FRAMES_SENT); end
    ARESET = 1'b0;
    exp_count = 0;
  endtask

  task automatic test_nominal();
    int mm;
    for (int i = 0; i < N; i++) nom_payload[N*8-1-8*i -: 8] = 8'(i + 1);
    build_expected(MAC_DST, MAC_SRC, IP_SRC, IP_DST, 16'(exp_count), nom_payload);
    @(negedge ACLK);
    checks++; if (READY !== 1'b1) begin errors++; $display("FAIL nom_ready_idle got %b expected 1", READY); end
    start_frame(MAC_DST, MAC_SRC, IP_SRC, IP_DST, nom_payload);
    checks++; if (READY !== 1'b0) begin errors++; $display("FAIL nom_ready_drop got %b expected 0", READY); end
    capture(100, -1);
    checks++; if (cap_timeout !== 1'b0) begin errors++; $display("FAIL nom_timeout got %b expected 0", cap_timeout); end
    checks++; if (cap_bytes.size() !== FB) begin errors++; $display("FAIL nom_length got %0d expected %0d", cap_bytes.size(), FB); end
    checks++; if (cap_last_pos !== FB - 1 || cap_nlast !== 1) begin errors++; $display("FAIL nom_tlast_pos got %0d expected %0d", cap_last_pos, FB - 1); end
    checks++; if ({cap_at(16), cap_at(17)} !== 16'h0325) begin errors++; $display("FAIL nom_total_len got %h expected 0325", {cap_at(16), cap_at(17)}); end
    checks++; if ({cap_at(18), cap_at(19)} !== 16'h0000) begin errors++; $display("FAIL nom_id got %h expected 0000", {cap_at(18), cap_at(19)}); end
    checks++; if ({cap_at(24), cap_at(25)} !== 16'h22DA) begin errors++; $display("FAIL nom_csum got %h expected 22da", {cap_at(24), cap_at(25)}); end
    checks++; if (cap_at(34) !== nom_payload[N*8-1 -: 8]) begin errors++; $display("FAIL nom_byte34 got %h expected %h", cap_at(34), nom_payload[N*8-1 -: 8]); end
    mm = frame_mismatches();
    checks++; if (mm !== 0) begin errors++; $display("FAIL nom_bytes got %0d mismatches (first %0d) expected 0", mm, first_bad); end
    checks++; if (cap_pre_idle !== 1 || cap_gaps !== 0) begin errors++; $display("FAIL nom_valid_timing got pre %0d gaps %0d expected 1 0", cap_pre_idle, cap_gaps); end
    @(negedge ACLK);
    exp_count++;
    checks++; if (FRAMES_SENT !== 16'(exp_count)) begin errors++; $display("FAIL nom_frames got %0d expected %0d", FRAMES_SENT, exp_count); end
    checks++; if (READY !== 1'b1 || TX_AXIS_TVALID !== 1'b0 || TX_AXIS_TLAST !== 1'b0) begin errors++; $display("FAIL nom_post got ready %b valid %b last %b expected 1 0 0", READY, TX_AXIS_TVALID, TX_AXIS_TLAST); end
  endtask

  task automatic test_back_to_back();
    int mm;
    do_reset();
    build_expected(MAC_DST, MAC_SRC, IP_SRC, IP_DST, 16'(exp_count), nom_payload);
    start_frame(MAC_DST, MAC_SRC, IP_SRC, IP_DST, nom_payload);
    capture(100, -1);
    mm = frame_mismatches();
    checks++; if (mm !== 0) begin errors++; $display("FAIL b2b_first_bytes got %0d mismatches (first %0d) expected 0", mm, first_bad); end
    @(negedge ACLK);
    exp_count++;
    checks++; if (READY !== 1'b1 || TX_AXIS_TVALID !== 1'b0) begin errors++; $display("FAIL b2b_ready_back got ready %b valid %b expected 1 0", READY, TX_AXIS_TVALID); end
    build_expected(MAC_DST, MAC_SRC, IP_SRC, IP_DST, 16'(exp_count), nom_payload);
    start_frame(MAC_DST, MAC_SRC, IP_SRC, IP_DST, nom_payload);
    capture(100, -1);
    checks++; if (cap_pre_idle + 1 !== 2) begin errors++; $display("FAIL b2b_gap got %0d expected 2", cap_pre_idle + 1); end
    checks++; if ({cap_at(18), cap_at(19)} !== 16'h0001) begin errors++; $display("FAIL b2b_id got %h expected 0001", {cap_at(18), cap_at(19)}); end
    checks++; if ({cap_at(24), cap_at(25)} !== 16'h22D9) begin errors++; $display("FAIL b2b_csum got %h expected 22d9", {cap_at(24), cap_at(25)}); end
    mm = frame_mismatches();
    checks++; if (mm !== 0) begin errors++; $display("FAIL b2b_second_bytes got %0d mismatches (first %0d) expected 0", mm, first_bad); end
    @(negedge ACLK);
    exp_count++;
    checks++; if (FRAMES_SENT !== 16'(exp_count)) begin errors++; $display("FAIL b2b_frames got %0d expected %0d", FRAMES_SENT, exp_count); end
  endtask

  task automatic test_backpressure();
    int mm;
    build_expected(MAC_DST, MAC_SRC, IP_SRC, IP_DST, 16'(exp_count), nom_payload);
    @(negedge ACLK);
    start_frame(MAC_DST, MAC_SRC, IP_SRC, IP_DST, nom_payload);
    capture(50, -1);
    checks++; if (cap_timeout !== 1'b0) begin errors++; $display("FAIL bp_timeout got %b expected 0", cap_timeout); end
    mm = frame_mismatches();
    checks++; if (mm !== 0 || cap_bytes.size() !== FB) begin errors++; $display("FAIL bp_bytes got %0d mismatches len %0d expected 0 len %0d", mm, cap_bytes.size(), FB); end
    checks++; if (cap_stall_err !== 0) begin errors++; $display("FAIL bp_stall_stable got %0d unstable cycles expected 0", cap_stall_err); end
    checks++; if (cap_gaps !== 0) begin errors++; $display("FAIL bp_gaps got %0d expected 0", cap_gaps); end
    checks++; if (cap_nlast !== 1 || cap_last_pos !== FB - 1) begin errors++; $display("FAIL bp_tlast got pos %0d expected %0d", cap_last_pos, FB - 1); end
    @(negedge ACLK);
    exp_count++;
    checks++; if (FRAMES_SENT !== 16'(exp_count)) begin errors++; $display("FAIL bp_frames got %0d expected %0d", FRAMES_SENT, exp_count); end
  endtask

  task automatic test_ignore_start();
    logic [47:0] dm, sm;
    logic [31:0] si, di;
    logic [N*8-1:0] pl;
    int mm;
    dm = 48'({$urandom, $urandom}); sm = 48'({$urandom, $urandom});
    si = $urandom; di = $urandom; pl = rand_payload();
    build_expected(dm, sm, si, di, 16'(exp_count), pl);
    @(negedge ACLK);
    start_frame(dm, sm, si, di, pl);
    drive_fields(48'({$urandom, $urandom}), 48'({$urandom, $urandom}), $urandom, $urandom, rand_payload());
    START = 1'b1;
    capture(75, -1);
    START = 1'b0;
    mm = frame_mismatches();
    checks++; if (mm !== 0) begin errors++; $display("FAIL ign_bytes got %0d mismatches (first %0d) expected 0", mm, first_bad); end
    checks++; if (cap_stall_err !== 0 || cap_gaps !== 0) begin errors++; $display("FAIL ign_protocol got stall %0d gaps %0d expected 0 0", cap_stall_err, cap_gaps); end
    @(negedge ACLK);
    exp_count++;
    checks++; if (FRAMES_SENT !== 16'(exp_count)) begin errors++; $display("FAIL ign_frames got %0d expected %0d", FRAMES_SENT, exp_count); end
    @(negedge ACLK);
    checks++; if (READY !== 1'b1 || TX_AXIS_TVALID !== 1'b0) begin errors++; $display("FAIL ign_not_queued got ready %b valid %b expected 1 0", READY, TX_AXIS_TVALID); end
  endtask

  task automatic test_carry_fold();
    int mm;
    do_reset();
    build_expected(MAC_DST, MAC_SRC, 32'hFFFF_FFFF, IP_DST, 16'(exp_count), nom_payload);
    start_frame(MAC_DST, MAC_SRC, 32'hFFFF_FFFF, IP_DST, nom_payload);
    capture(100, -1);
    checks++; if ({cap_at(24), cap_at(25)} !== 16'h2CDC) begin errors++; $display("FAIL fold_csum got %h expected 2cdc", {cap_at(24), cap_at(25)}); end
    mm = frame_mismatches();
    checks++; if (mm !== 0) begin errors++; $display("FAIL fold_bytes got %0d mismatches (first %0d) expected 0", mm, first_bad); end
    @(negedge ACLK);
    exp_count++;
  endtask

  task automatic test_abort();
    int mm;
    do_reset();
    start_frame(MAC_DST, MAC_SRC, IP_SRC, IP_DST, nom_payload);
    capture(100, 100);
    checks++; if (cap_timeout !== 1'b0 || cap_bytes.size() !== 100) begin errors++; $display("FAIL abort_reach got %0d bytes expected 100", cap_bytes.size()); end
    checks++; if (cap_nlast !== 0) begin errors++; $display("FAIL abort_no_tlast got %0d expected 0", cap_nlast); end
    @(negedge ACLK);
    ARESET = 1'b0;
    exp_count = 0;
    checks++; if (TX_AXIS_TVALID !== 1'b0 || TX_AXIS_TLAST !== 1'b0) begin errors++; $display("FAIL abort_outputs got valid %b last %b expected 0 0", TX_AXIS_TVALID, TX_AXIS_TLAST); end
    checks++; if (READY !== 1'b1 || TX_AXIS_TDATA !== 8'h00) begin errors++; $display("FAIL abort_ready got ready %b data %h expected 1 00", READY, TX_AXIS_TDATA); end
    checks++; if (FRAMES_SENT !== 16'h0000) begin errors++; $display("FAIL abort_frames got %h expected 0000", FRAMES_SENT); end
    build_expected(MAC_DST, MAC_SRC, IP_SRC, IP_DST, 16'(exp_count), nom_payload);
    start_frame(MAC_DST, MAC_SRC, IP_SRC, IP_DST, nom_payload);
    capture(100, -1);
    checks++; if ({cap_at(18), cap_at(19)} !== 16'h0000) begin errors++; $display("FAIL abort_next_id got %h expected 0000", {cap_at(18), cap_at(19)}); end
    mm = frame_mismatches();
    checks++; if (mm !== 0 || cap_bytes.size() !== FB) begin errors++; $display("FAIL abort_next_bytes got %0d mismatches len %0d expected 0 len %0d", mm, cap_bytes.size(), FB); end
    @(negedge ACLK);
    exp_count++;
    checks++; if (FRAMES_SENT !== 16'(exp_count)) begin errors++; $display("FAIL abort_next_frames got %0d expected %0d", FRAMES_SENT, exp_count); end
  endtask

  task automatic test_reset_with_start();
    @(negedge ACLK);
    drive_fields(MAC_DST, MAC_SRC, IP_SRC, IP_DST, nom_payload);
    ARESET = 1'b1; START = 1'b1;
    @(negedge ACLK);
    ARESET = 1'b0; START = 1'b0;
    exp_count = 0;
    checks++; if (READY !== 1'b1 || FRAMES_SENT !== 16'h0000) begin errors++; $display("FAIL rst_start_ready got ready %b frames %h expected 1 0000", READY, FRAMES_SENT); end
    @(negedge ACLK);
    checks++; if (TX_AXIS_TVALID !== 1'b0 || READY !== 1'b1) begin errors++; $display("FAIL rst_start_dropped got valid %b ready %b expected 0 1", TX_AXIS_TVALID, READY); end
  endtask

  task automatic test_random_frames();
    logic [47:0] dm, sm;
    logic [31:0] si, di;
    logic [N*8-1:0] pl;
    int mm;
    for (int f = 0; f < 2; f++) begin
      dm = 48'({$urandom, $urandom}); sm = 48'({$urandom, $urandom});
      si = $urandom; di = $urandom; pl = rand_payload();
      build_expected(dm, sm, si, di, 16'(exp_count), pl);
      @(negedge ACLK);
      start_frame(dm, sm, si, di, pl);
      capture(60, -1);
      mm = frame_mismatches();
      checks++; if (mm !== 0 || cap_bytes.size() !== FB) begin errors++; $display("FAIL rand_bytes_%0d got %0d mismatches len %0d expected 0 len %0d", f, mm, cap_bytes.size(), FB); end
      checks++; if (cap_stall_err !== 0 || cap_gaps !== 0 || cap_nlast !== 1) begin errors++; $display("FAIL rand_protocol_%0d got stall %0d gaps %0d last %0d expected 0 0 1", f, cap_stall_err, cap_gaps, cap_nlast); end
      @(negedge ACLK);
      exp_count++;
      checks++; if (FRAMES_SENT !== 16'(exp_count)) begin errors++; $display("FAIL rand_frames_%0d got %0d expected %0d", f, FRAMES_SENT, exp_count); end
    end
  endtask

  initial begin
    ARESET = 1'b1; START = 1'b0; TX_AXIS_TREADY = 1'b0;
    SRC_IP_ADDRESS = '0; SRC_MAC_ADDRESS = '0;
    DEST_IP_ADDRESS = '0; DEST_MAC_ADDRESS = '0; PAYLOAD = '0;
    nom_payload = '0;
    test_reset();
    test_nominal();
    test_back_to_back();
    test_backpressure();
    test_ignore_start();
    test_carry_fold();
    test_abort();
    test_reset_with_start();
    test_random_frames();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
